// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - single-port SRAM request/response controller with 2-entry credit-managed response FIFO
// Optional performance counters (rd_cnt_o / wr_cnt_o) are built when SRAM_PORT_CTRL_PERF_EN is defined.
module sram_port_ctrl #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_v_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [BITS-1:0]       req_data_i,
  input  logic [BITS-1:0]       req_mask_i,
  output logic                  resp_v_o,
  output logic [BITS-1:0]       resp_data_o,
  input  logic                  resp_ready_i,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [BITS-1:0]       ram_wd_o,
  output logic [BITS-1:0]       ram_mask_o,
  input  logic [BITS-1:0]       ram_rd_i,
  output logic                  busy_o
`ifdef SRAM_PORT_CTRL_PERF_EN
  ,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
`endif
);

  if (WORD_DEPTH < 1 || WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sram_port_ctrl: WORD_DEPTH does not fit in ADDR_WIDTH address bits");
  end

  logic            acc;
  logic            pop;
  logic            push;
  logic            rd_pend;
  logic [1:0]      cnt;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [2:0]      credit;
  logic [BITS-1:0] fifo_mem [2];

  assign acc  = req_v_i & req_ready_o;
  assign pop  = resp_v_o & resp_ready_i;
  assign push = rd_pend;

  // A read is only accepted when a FIFO slot is guaranteed for its data,
  // counting the read already in flight and the slot freed by this cycle's pop.
  assign credit      = {1'b0, cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign req_ready_o = rst_n & (credit < 3'd2);

  assign ram_ce_o   = acc;
  assign ram_we_o   = req_we_i;
  assign ram_addr_o = req_addr_i;
  assign ram_wd_o   = req_data_i;
  assign ram_mask_o = req_mask_i;

  assign resp_v_o    = (cnt != 2'd0);
  assign resp_data_o = fifo_mem[rd_ptr];
  assign busy_o      = rd_pend | (cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend     <= 1'b0;
      cnt         <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      rd_pend <= acc & ~req_we_i;
      if (push) begin
        fifo_mem[wr_ptr] <= ram_rd_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef SRAM_PORT_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_o <= 32'd0;
      wr_cnt_o <= 32'd0;
    end else if (acc) begin
      if (req_we_i) begin
        wr_cnt_o <= wr_cnt_o + 32'd1;
      end else begin
        rd_cnt_o <= rd_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
